fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameters SHALL be, one per line:
- REG_AW, 5, register-address width.
- NUM_SRC, 2, source operands per instruction in EX.
- DEPTH, 3, number of tracked producer stages beyond EX (entry0 = EX/MEM, entry1 = MEM/WB, ...).
- LOAD_STAGE, 1, first entry index at which load data is forwardable.
- SELW, clog2(DEPTH+1), width of one forward select.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-high.
- ex_valid, in, 1, EX holds a real instruction.
- ex_rd, in, REG_AW, EX destination register.
- ex_regwrite, in, 1, EX instruction writes a register.
- ex_memread, in, 1, EX instruction is a load.
- ex_src, in, NUM_SRC*REG_AW, EX source registers; source i at bits [i*REG_AW +: REG_AW].
- flush, in, 1, kill the EX instruction this cycle.
- fwd_sel, out, NUM_SRC*SELW, per-source select; 0 = register file, k+1 = entry k.
- stall, out, 1, freeze PC/IF/ID/EX this cycle.
- stall_cnt, out, 16, saturating count of stall cycles.

Function
REQ-003 Tracker:
- DEPTH-entry shift register; each entry holds {valid, rd, regwrite, memread}.
- Every cycle: entry k+1 <= entry k; entry0 <= EX info, or a bubble (valid=0) when stall or flush.
REQ-004 Match rule: entry k matches source i iff valid && regwrite && rd != 0 && rd == src_i.
REQ-005 Priority: fwd_sel[i] SHALL select the lowest-index (youngest) matching entry; 0 if none.
REQ-006 Readiness: entry k is ready iff !memread || k >= LOAD_STAGE.
REQ-007 Hazard: hazard = ex_valid && (some source's youngest match is not ready).
REQ-008 Hazard outputs: when hazard, stall=1 and fwd_sel for that source SHALL still show the youngest match (the pipeline ignores it); older matches SHALL NOT be chosen.
REQ-009 Timing: fwd_sel and stall are combinational from current state and EX inputs, with zero-cycle latency.
REQ-010 Flush:
- flush=1 forces stall=0 and inserts a bubble.
- Flush beats a simultaneous hazard.
- Older entries keep shifting.
REQ-011 FSM states RUN and STALL:
- RUN->STALL on stall=1.
- STALL->RUN on stall=0.
- STALL->STALL while the hazard persists; the bounded form is LOAD_STAGE consecutive cycles.
REQ-012 stall_cnt SHALL increment by 1 on each clock where stall=1 and SHALL hold at 16'hFFFF.
REQ-013 Register 0 is never forwarded or stalled on, whether it appears as rd or as a source.
REQ-014 NUM_SRC sources SHALL be evaluated independently; any single hazard asserts stall.

Reset
REQ-015 Asserting reset SHALL immediately clear all entries to invalid, set the FSM to RUN and set stall_cnt to 0.
REQ-016 During reset: fwd_sel = 0 and stall = 0.
REQ-017 Reset mid-stall SHALL discard the pending hazard; the first post-reset cycle SHALL NOT stall.
REQ-018 Deassertion SHALL take effect on the next clk edge without glitching outputs.

Structure
REQ-019 Shared package fwd_pkg SHALL hold:
- the FSM state enum (RUN, STALL);
- the tracker-entry struct;
- the select encoding constants (SEL_RF = 0);
- the SELW width function.
REQ-020 Sub-module fwd_match SHALL implement one source's priority match and readiness against all entries; it is instantiated NUM_SRC times.
REQ-021 Tracker, FSM and counter SHALL live in fwd_hazard_unit.
REQ-022 No other sub-modules.

Verification (defaults: DEPTH=3, LOAD_STAGE=1)
REQ-023 ALU chain: add r3 then a consumer with src0=r3 next cycle -> fwd_sel[0]=1, stall=0.
REQ-024 Double producer:
- Sequence: r5 written twice on consecutive cycles, then a consumer with src1=r5.
- Required response: fwd_sel[1]=1 (youngest), never 2.
REQ-025 Load-use:
- Sequence: lw r7, then a consumer with src0=r7.
- Required response: stall=1 for exactly 1 cycle; stall_cnt=1; next cycle fwd_sel[0]=2, stall=0.
REQ-026 Register 0 and flush:
- Producer writes r0, consumer src0=r0 -> fwd_sel[0]=0.
- Load-use hazard with flush=1 the same cycle -> stall=0 and a bubble is inserted.
REQ-027 Reset and saturation:
- Assert reset during a stall -> entries cleared, stall=0 immediately.
- Force stall_cnt to 16'hFFFF -> a further stall leaves it at 16'hFFFF.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
package fwd_pkg;

    // Storage width of rd inside a tracker entry.
    // Narrower register addresses are zero-extended into this field.
    localparam int unsigned TRK_RD_W = 8;

    // Select value meaning "read the register file".
    localparam int unsigned SEL_RF = 0;

    // Pipeline control state: normal flow or frozen front end.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } fsm_state_t;

    // One in-flight producer tracked beyond EX.
    typedef struct packed {
        logic                valid;
        logic [TRK_RD_W-1:0] rd;
        logic                regwrite;
        logic                memread;
    } trk_entry_t;

    // Width of one forward select: register file plus one code per entry.
    function automatic int unsigned sel_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority match of one EX source operand against all tracker entries.
// Reports the youngest matching producer and whether its data is not yet available.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_STAGE = 1,
    parameter int unsigned SELW       = sel_width(DEPTH)
) (
    input  trk_entry_t [DEPTH-1:0] entries,
    input  logic [REG_AW-1:0]      src,
    output logic [SELW-1:0]        sel_c,
    output logic                   hazard_c
);

    logic [TRK_RD_W-1:0] src_ext;

    assign src_ext = TRK_RD_W'(src);

    // Walk from oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        sel_c    = SELW'(SEL_RF);
        hazard_c = 1'b0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (entries[k].valid && entries[k].regwrite &&
                (entries[k].rd != '0) && (entries[k].rd == src_ext)) begin
                sel_c    = SELW'(k + 1);
                hazard_c = entries[k].memread && (k < int'(LOAD_STAGE));
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation for the EX stage.
// Tracks producers beyond EX in a shift register, resolves per-source
// forwarding, freezes the front end on an unready youngest producer,
// and counts stall cycles.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_STAGE = 1,
    parameter int unsigned SELW       = sel_width(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ex_valid,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      ex_regwrite,
    input  logic                      ex_memread,
    input  logic [NUM_SRC*REG_AW-1:0] ex_src,
    input  logic                      flush,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic                      stall,
    output logic [15:0]               stall_cnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    trk_entry_t [DEPTH-1:0]    trk_q;
    trk_entry_t                ex_entry;
    logic [NUM_SRC*SELW-1:0]   sel_raw;
    logic [NUM_SRC-1:0]        src_hazard;
    logic                      hazard;
    logic                      stall_int;
    fsm_state_t                state_q;
    fsm_state_t                state_d;
    logic [15:0]               stall_cnt_q;

    // Snapshot of the instruction currently in EX.
    always_comb begin
        ex_entry          = '0;
        ex_entry.valid    = ex_valid;
        ex_entry.rd       = TRK_RD_W'(ex_rd);
        ex_entry.regwrite = ex_regwrite;
        ex_entry.memread  = ex_memread;
    end

    // One independent matcher per source operand.
    for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_src
        fwd_match #(
            .REG_AW     (REG_AW),
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE),
            .SELW       (SELW)
        ) u_match (
            .entries  (trk_q),
            .src      (ex_src[i*REG_AW +: REG_AW]),
            .sel_c    (sel_raw[i*SELW +: SELW]),
            .hazard_c (src_hazard[i])
        );
    end

    // Any source waiting on an unready producer freezes the front end; flush wins.
    always_comb begin
        hazard    = ex_valid && (|src_hazard);
        stall_int = hazard && !flush;
    end

    // Outputs forced quiet while reset is held.
    always_comb begin
        fwd_sel = reset ? '0 : sel_raw;
        stall   = stall_int && !reset;
    end

    assign stall_cnt = stall_cnt_q;

    // Producer tracker: age every entry, inject EX or a bubble at the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trk_q <= '0;
        end else begin
            for (int k = 1; k < int'(DEPTH); k++) begin
                trk_q[k] <= trk_q[k-1];
            end
            trk_q[0] <= (stall_int || flush) ? trk_entry_t'('0) : ex_entry;
        end
    end

    // Pipeline control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: enter STALL on a stall cycle, return to RUN once it clears.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (stall_int)  state_d = STALL;
            STALL:   if (!stall_int) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
        end else if (stall_int && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed scenarios plus random traffic
// checked against a queue-based model of in-flight producers.
module tb_fwd_hazard_unit;

    localparam int unsigned REG_AW     = 5;
    localparam int unsigned NUM_SRC    = 2;
    localparam int unsigned DEPTH      = 3;
    localparam int unsigned LOAD_STAGE = 1;
    localparam int unsigned SELW       = 2;

    logic                      clk;
    logic                      reset;
    logic                      ex_valid;
    logic [REG_AW-1:0]         ex_rd;
    logic                      ex_regwrite;
    logic                      ex_memread;
    logic [NUM_SRC*REG_AW-1:0] ex_src;
    logic                      flush;
    logic [NUM_SRC*SELW-1:0]   fwd_sel;
    logic                      stall;
    logic [15:0]               stall_cnt;

    fwd_hazard_unit #(
        .REG_AW     (REG_AW),
        .NUM_SRC    (NUM_SRC),
        .DEPTH      (DEPTH),
        .LOAD_STAGE (LOAD_STAGE),
        .SELW       (SELW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_regwrite (ex_regwrite),
        .ex_memread  (ex_memread),
        .ex_src      (ex_src),
        .flush       (flush),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_SRC*SELW-1:0] sel;
        logic                    stall;
        logic [15:0]             cnt;
        string                   name;
    } exp_t;

    typedef struct {
        bit valid;
        int rd;
        bit rw;
        bit mr;
    } prod_t;

    exp_t  exp_q[$];
    prod_t hist[$];     // front = youngest producer beyond EX
    int    m_cnt;
    bit    m_last_stall;
    int    vectors;
    int    miscompares;

    function automatic void model_clear();
        prod_t b;
        b = '{valid: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
        hist.delete();
        for (int k = 0; k < int'(DEPTH); k++) hist.push_back(b);
        m_cnt        = 0;
        m_last_stall = 1'b0;
    endfunction

    // Drive one EX cycle and record the response the pipeline rules demand.
    task automatic drive(input string name, input bit rst, input bit v, input int rd,
                         input bit rw, input bit mr, input int s0, input int s1, input bit fl);
        exp_t  e;
        prod_t p;
        int    srcs[2];
        int    sel_i;
        bit    haz;
        bit    st;
        @(posedge clk);
        #1;
        reset       = rst;
        ex_valid    = v;
        ex_rd       = REG_AW'(rd);
        ex_regwrite = rw;
        ex_memread  = mr;
        ex_src      = {REG_AW'(s1), REG_AW'(s0)};
        flush       = fl;
        e.name = name;
        e.sel  = '0;
        if (rst) begin
            model_clear();
            e.stall = 1'b0;
            e.cnt   = 16'd0;
        end else begin
            srcs[0] = s0;
            srcs[1] = s1;
            haz = 1'b0;
            for (int i = 0; i < 2; i++) begin
                bit found;
                found = 1'b0;
                sel_i = 0;
                for (int k = 0; k < hist.size(); k++) begin
                    if (!found && hist[k].valid && hist[k].rw && hist[k].rd != 0 &&
                        hist[k].rd == srcs[i]) begin
                        found = 1'b1;
                        sel_i = k + 1;
                        if (hist[k].mr && k < int'(LOAD_STAGE)) haz = 1'b1;
                    end
                end
                e.sel[i*SELW +: SELW] = SELW'(sel_i);
            end
            st      = v && haz && !fl;
            e.stall = st;
            e.cnt   = 16'(m_cnt);
            if (st && m_cnt < 65535) m_cnt++;
            if (st || fl) p = '{valid: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
            else          p = '{valid: v, rd: rd, rw: rw, mr: mr};
            hist.push_front(p);
            void'(hist.pop_back());
            m_last_stall = st;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (fwd_sel !== e.sel || stall !== e.stall || stall_cnt !== e.cnt) begin
                miscompares++;
                $display("FAIL %s: got sel=%h stall=%b cnt=%h, expected sel=%h stall=%b cnt=%h",
                         e.name, fwd_sel, stall, stall_cnt, e.sel, e.stall, e.cnt);
            end
        end
    end

    initial begin
        int r_v, r_rd, r_rw, r_mr, r_s0, r_s1;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        ex_valid    = 1'b0;
        ex_rd       = '0;
        ex_regwrite = 1'b0;
        ex_memread  = 1'b0;
        ex_src      = '0;
        flush       = 1'b0;
        model_clear();

        drive("reset_state", 1, 0, 0, 0, 0, 0, 0, 0);
        drive("idle",        0, 0, 0, 0, 0, 0, 0, 0);

        // ALU chain
        drive("add_r3",      0, 1, 3, 1, 0, 1, 2, 0);
        drive("use_r3",      0, 1, 4, 1, 0, 3, 0, 0);
        drive("idle2",       0, 0, 0, 0, 0, 0, 0, 0);

        // Double producer: youngest r5 must win
        drive("r5_first",    0, 1, 5, 1, 0, 0, 0, 0);
        drive("r5_second",   0, 1, 5, 1, 0, 0, 0, 0);
        drive("use_r5_src1", 0, 1, 6, 1, 0, 0, 5, 0);
        drive("idle3",       0, 0, 0, 0, 0, 0, 0, 0);

        // Load-use: one stall, then forward from entry1
        drive("lw_r7",       0, 1, 7, 1, 1, 0, 0, 0);
        drive("use_r7_stall",0, 1, 8, 1, 0, 7, 0, 0);
        drive("use_r7_fwd",  0, 1, 8, 1, 0, 7, 0, 0);

        // Register 0 is never forwarded
        drive("write_r0",    0, 1, 0, 1, 0, 0, 0, 0);
        drive("use_r0",      0, 1, 9, 1, 0, 0, 0, 0);

        // Flush beats a load-use hazard and injects a bubble
        drive("lw_r7_b",     0, 1, 7, 1, 1, 0, 0, 0);
        drive("use_r7_flush",0, 1, 8, 1, 0, 7, 0, 1);
        drive("use_r7_after",0, 1, 8, 1, 0, 7, 0, 0);

        // Reset in the middle of a stall
        drive("lw_r9",       0, 1, 9, 1, 1, 0, 0, 0);
        drive("use_r9_stall",0, 1, 10, 1, 0, 0, 9, 0);
        drive("reset_mid",   1, 1, 10, 1, 0, 0, 9, 0);
        drive("post_reset",  0, 1, 10, 1, 0, 0, 9, 0);

        // Counter saturation
        drive("idle_pre_sat",0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 65534;
        drive("sat_lw_r7",   0, 1, 7, 1, 1, 0, 0, 0);
        drive("sat_stall1",  0, 1, 8, 1, 0, 7, 7, 0);
        drive("sat_fwd1",    0, 1, 8, 1, 0, 7, 7, 0);
        drive("sat_lw_r12",  0, 1, 12, 1, 1, 0, 0, 0);
        drive("sat_stall2",  0, 1, 13, 1, 0, 12, 0, 0);
        drive("sat_hold",    0, 1, 13, 1, 0, 12, 0, 0);

        // Random traffic; a stalled EX instruction is held like a real pipeline
        r_v = 0; r_rd = 0; r_rw = 0; r_mr = 0; r_s0 = 0; r_s1 = 0;
        for (int n = 0; n < 600; n++) begin
            bit r_fl;
            bit r_rst;
            if (!m_last_stall) begin
                r_v  = ($urandom_range(0, 9) != 0) ? 1 : 0;
                r_rd = $urandom_range(0, 7);
                r_rw = ($urandom_range(0, 9) < 7) ? 1 : 0;
                r_mr = ($urandom_range(0, 9) < 3) ? 1 : 0;
                r_s0 = $urandom_range(0, 7);
                r_s1 = $urandom_range(0, 7);
            end
            r_fl  = ($urandom_range(0, 9) == 0);
            r_rst = ($urandom_range(0, 49) == 0);
            drive("random", r_rst, r_v[0], r_rd, r_rw[0], r_mr[0], r_s0, r_s1, r_fl);
        end

        // Bounded drain of the scoreboard
        for (int t = 0; t < 4 && exp_q.size() > 0; t++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d responses never checked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
